// File: rtl/cu_prefetch_stream_arbiter_pkg.sv
// Shared types and defaults for the prefetch stream arbiter.
//
// Contents:
//   arb_state_t          arbiter FSM encoding (IDLE / RUN / DRAIN)
//   CommandBufferLine    one command-buffer entry (valid, cu_id, command, address, size)
//   ResponseBufferLine   one response entry (valid, originating command, data)
//   BufferStatus         alfull / full / empty flags
//   STREAM_ARB_*         default FIFO depth and almost-full level
//   status_from_count    occupancy -> BufferStatus
package cu_prefetch_stream_arbiter_pkg;

  localparam int CU_ID_W = 8;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  localparam logic [CU_ID_W-1:0] PREFETCH_READ_CONTROL_ID = 8'h20;

  localparam int STREAM_ARB_FIFO_DEPTH   = 4;
  localparam int STREAM_ARB_ALFULL_LEVEL = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic               valid;
    logic [CU_ID_W-1:0] cu_id;
    logic [3:0]         command;
    logic [ADDR_W-1:0]  address;
    logic [7:0]         size;
  } CommandBufferLine;

  typedef struct packed {
    logic             valid;
    CommandBufferLine cmd;
    logic [DATA_W-1:0] data;
  } ResponseBufferLine;

  typedef struct packed {
    logic alfull;
    logic full;
    logic empty;
  } BufferStatus;

  function automatic BufferStatus status_from_count(input int unsigned count,
                                                    input int unsigned depth,
                                                    input int unsigned alfull_level);
    BufferStatus s;
    s.alfull = (count >= alfull_level);
    s.full   = (count == depth);
    s.empty  = (count == 0);
    return s;
  endfunction

endpackage

// File: rtl/cu_prefetch_stream_fifo.sv
// Per-stream skid FIFO holding CommandBufferLine entries.
//
// Ports:
//   clock      in   system clock
//   rst        in   asynchronous reset, active-high
//   push       in   enqueue push_data (dropped if full and not popping this cycle)
//   push_data  in   entry to enqueue
//   pop        in   dequeue head (ignored when empty)
//   head       out  current head entry (valid only while not_empty)
//   not_empty  out  combinational occupancy != 0, used by the arbiter
//   status     out  registered alfull/full/empty, one cycle behind occupancy
//   overflow   out  sticky: a push was dropped because the FIFO was full
module cu_prefetch_stream_fifo
  import cu_prefetch_stream_arbiter_pkg::*;
#(
  parameter int DEPTH        = STREAM_ARB_FIFO_DEPTH,
  parameter int ALFULL_LEVEL = STREAM_ARB_ALFULL_LEVEL
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  CommandBufferLine push_data,
  input  logic             pop,
  output CommandBufferLine head,
  output logic             not_empty,
  output BufferStatus      status,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  CommandBufferLine mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             is_full;
  logic             do_push;
  logic             do_pop;

  assign is_full   = (count == CNT_W'(DEPTH));
  assign not_empty = (count != '0);
  assign do_pop    = pop & not_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push   = push & (~is_full | do_pop);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      status   <= status_from_count(0, DEPTH, ALFULL_LEVEL);
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Deliberately sampled from the pre-update occupancy; the almost-full
      // margin absorbs the extra cycle of engine latency.
      status <= status_from_count(32'(count), DEPTH, ALFULL_LEVEL);
      if (push & ~do_push) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cu_prefetch_stream_arbiter.sv
// Shares one prefetch command buffer between NUM_STREAMS prefetch engines.
// Each engine pushes into its own skid FIFO; FIFOs drain round-robin into
// command_out. Responses are routed back to the owning engine by cmd.cu_id.
//
// Optional build macro: PREFETCH_ARB_STARVE_GUARD_EN
//   Adds per-stream 8-bit wait counters; a stream whose counter hits 255 is
//   granted ahead of round-robin (lowest index first). Undefined: pure
//   round-robin, no counters.
//
// Ports:
//   clock                  in   system clock
//   rst                    in   asynchronous reset, active-high
//   enabled_in             in   global enable
//   stream_command_in      in   per-engine command, pushed when .valid
//   stream_buffer_status   out  per-FIFO alfull/full/empty to the engines
//   command_buffer_status  in   downstream command buffer status
//   command_out            out  arbitrated command, one-cycle pulse
//   response_in            in   shared response stream
//   stream_response_out    out  routed responses, one-cycle latency
//   stream_overflow        out  sticky per-stream push-while-full flag
//
// FSM states:
//   state | meaning
//   IDLE  | disabled and drained; pushes accepted, no grants
//   RUN   | enabled; grants each cycle downstream has room
//   DRAIN | disabled with queued commands; keep granting until all FIFOs empty
module cu_prefetch_stream_arbiter
  import cu_prefetch_stream_arbiter_pkg::*;
#(
  parameter int                 NUM_STREAMS    = 4,
  parameter logic [CU_ID_W-1:0] STREAM_ID_BASE = PREFETCH_READ_CONTROL_ID,
  parameter int                 FIFO_DEPTH     = STREAM_ARB_FIFO_DEPTH,
  parameter int                 ALFULL_LEVEL   = STREAM_ARB_ALFULL_LEVEL
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              enabled_in,
  input  CommandBufferLine  stream_command_in [NUM_STREAMS],
  output BufferStatus       stream_buffer_status [NUM_STREAMS],
  input  BufferStatus       command_buffer_status,
  output CommandBufferLine  command_out,
  input  ResponseBufferLine response_in,
  output ResponseBufferLine stream_response_out [NUM_STREAMS],
  output logic [NUM_STREAMS-1:0] stream_overflow
);

  localparam int IDX_W = $clog2(NUM_STREAMS);

  arb_state_t       state_q;
  arb_state_t       state_d;
  logic             grant_en;
  logic             any_pending;
  logic             downstream_stall;
  logic             status_empty_unused;

  CommandBufferLine fifo_head [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] fifo_not_empty;
  logic [NUM_STREAMS-1:0] pop;

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;

  // A full downstream buffer is treated like almost-full; its empty flag is not needed.
  assign downstream_stall    = command_buffer_status.alfull | command_buffer_status.full;
  assign status_empty_unused = command_buffer_status.empty;
  assign any_pending         = |fifo_not_empty;

  for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_fifo
    cu_prefetch_stream_fifo #(
      .DEPTH        (FIFO_DEPTH),
      .ALFULL_LEVEL (ALFULL_LEVEL)
    ) u_fifo (
      .clock     (clock),
      .rst       (rst),
      .push      (stream_command_in[i].valid),
      .push_data (stream_command_in[i]),
      .pop       (pop[i]),
      .head      (fifo_head[i]),
      .not_empty (fifo_not_empty[i]),
      .status    (stream_buffer_status[i]),
      .overflow  (stream_overflow[i])
    );
  end

  // State register
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enabled_in) state_d = RUN;
      RUN:     if (!enabled_in) state_d = any_pending ? DRAIN : IDLE;
      DRAIN: begin
        if (enabled_in)        state_d = RUN;
        else if (!any_pending) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    grant_en = (state_q == RUN) || (state_q == DRAIN);
  end

`ifdef PREFETCH_ARB_STARVE_GUARD_EN
  logic [7:0]             wait_cnt [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] starved;

  always_comb begin
    for (int s = 0; s < NUM_STREAMS; s++) begin
      starved[s] = fifo_not_empty[s] && (wait_cnt[s] == 8'hFF);
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_STREAMS; s++) wait_cnt[s] <= '0;
    end else begin
      for (int s = 0; s < NUM_STREAMS; s++) begin
        if (pop[s])
          wait_cnt[s] <= '0;
        else if (fifo_not_empty[s] && (wait_cnt[s] != 8'hFF))
          wait_cnt[s] <= wait_cnt[s] + 1'b1;
      end
    end
  end
`endif

  // Grant selection: first non-empty FIFO after last_grant, wrapping.
  always_comb begin : p_grant
    int  cand;
    logic forced;
    cand        = 0;
    forced      = 1'b0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (grant_en && !downstream_stall) begin
      for (int k = 1; k <= NUM_STREAMS; k++) begin
        cand = (int'(last_grant) + k) % NUM_STREAMS;
        if (!grant_valid && fifo_not_empty[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = IDX_W'(cand);
        end
      end
`ifdef PREFETCH_ARB_STARVE_GUARD_EN
      for (int s = 0; s < NUM_STREAMS; s++) begin
        if (!forced && starved[s]) begin
          forced      = 1'b1;
          grant_valid = 1'b1;
          grant_idx   = IDX_W'(s);
        end
      end
`endif
    end
  end

  always_comb begin
    pop = '0;
    if (grant_valid) pop[grant_idx] = 1'b1;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      last_grant  <= IDX_W'(NUM_STREAMS - 1);
      command_out <= '0;
    end else begin
      if (grant_valid) last_grant <= grant_idx;
      command_out <= grant_valid ? fifo_head[grant_idx] : '0;
    end
  end

  // Response routing runs regardless of FSM state; unmatched cu_ids vanish.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STREAMS; i++) stream_response_out[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        if (response_in.valid &&
            (response_in.cmd.cu_id == STREAM_ID_BASE + CU_ID_W'(i)))
          stream_response_out[i] <= response_in;
        else
          stream_response_out[i] <= '0;
      end
    end
  end

endmodule
